// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - transmit sample FIFO between the register block and the I2S serializer
// Registered read port, occupancy counter, threshold flags and sticky overflow/underflow.
module tx_fifo #(
   parameter int DW        = 32,
   parameter int DEPTH     = 8,
   parameter int AFULL_TH  = 6,
   parameter int AEMPTY_TH = 2,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic          pclk,
   input  logic          preset,
   input  logic          Tx_wen,
   input  logic [DW-1:0] Tx_data,
   input  logic          rd_en,
   input  logic          flush,
   input  logic          err_clr,
   output logic [DW-1:0] dout,
   output logic          dout_vld,
   output logic          Tx_full,
   output logic          Tx_empty,
   output logic          Tx_afull,
   output logic          Tx_aempty,
   output logic [AW:0]   Tx_level,
   output logic          Tx_ovf,
   output logic          Tx_udf
);

   localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_AFULL = (AW+1)'(AFULL_TH);
   localparam logic [AW:0]   LVL_AEMP  = (AW+1)'(AEMPTY_TH);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   logic [DW-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          dout_vld_q, dout_vld_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;

   logic rd_acc, wr_acc, ovf_evt, udf_evt;

   // A read frees a slot in the same cycle, so a full FIFO can still take a write.
   always_comb begin
      rd_acc  = rd_en && !flush && (level_q != '0);
      wr_acc  = Tx_wen && !flush && ((level_q != LVL_FULL) || rd_acc);
      ovf_evt = Tx_wen && !flush && !wr_acc;
      udf_evt = rd_en && !flush && (level_q == '0);
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      dout_d     = dout_q;
      dout_vld_d = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            dout_d     = mem[rd_ptr_q];
            dout_vld_d = 1'b1;
         end
         if (wr_acc && !rd_acc) level_d = level_q + LVL_ONE;
         if (rd_acc && !wr_acc) level_d = level_q - LVL_ONE;
      end
   end

   // Set wins over clear so an error coinciding with err_clr is not lost.
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (err_clr) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (ovf_evt) ovf_d = 1'b1;
      if (udf_evt) udf_d = 1'b1;
   end

   always_ff @(posedge pclk) begin
      if (wr_acc && !preset) mem[wr_ptr_q] <= Tx_data;
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   assign dout      = dout_q;
   assign dout_vld  = dout_vld_q;
   assign Tx_level  = level_q;
   assign Tx_full   = (level_q == LVL_FULL);
   assign Tx_empty  = (level_q == '0);
   assign Tx_afull  = (level_q >= LVL_AFULL);
   assign Tx_aempty = (level_q <= LVL_AEMP);
   assign Tx_ovf    = ovf_q;
   assign Tx_udf    = udf_q;

endmodule

// File: tb/tb_tx_fifo.sv
// tb/tb_tx_fifo.sv - scoreboard bench for tx_fifo against a queue-based reference model
module tb_tx_fifo;

   localparam int DW = 32;
   localparam int DEPTH = 8;

   logic          pclk = 1'b0;
   logic          preset, Tx_wen, rd_en, flush, err_clr;
   logic [DW-1:0] Tx_data;
   logic [DW-1:0] dout;
   logic          dout_vld, Tx_full, Tx_empty, Tx_afull, Tx_aempty, Tx_ovf, Tx_udf;
   logic [3:0]    Tx_level;

   tx_fifo dut (
      .pclk(pclk), .preset(preset), .Tx_wen(Tx_wen), .Tx_data(Tx_data),
      .rd_en(rd_en), .flush(flush), .err_clr(err_clr),
      .dout(dout), .dout_vld(dout_vld), .Tx_full(Tx_full), .Tx_empty(Tx_empty),
      .Tx_afull(Tx_afull), .Tx_aempty(Tx_aempty), .Tx_level(Tx_level),
      .Tx_ovf(Tx_ovf), .Tx_udf(Tx_udf)
   );

   always #5 pclk = ~pclk;

   logic [DW-1:0] fifo_m [$];
   logic [DW-1:0] exp_q  [$];
   logic [DW-1:0] m_dout;
   logic          m_ovf, m_udf;
   int            n_vec = 0;
   int            n_err = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every dout_vld pulse must match the oldest expected word.
   always @(posedge pclk) begin
      #1;
      if (dout_vld === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL spurious_vld: dout_vld=1 dout=0x%0h expected no output at %0t", dout, $time);
         end else begin
            logic [DW-1:0] w;
            w = exp_q.pop_front();
            if (dout !== w) begin
               n_err++;
               $display("FAIL dout_data: got 0x%0h expected 0x%0h at %0t", dout, w, $time);
            end
         end
      end
   end

   task automatic cycle(input logic wen, input logic [DW-1:0] data, input logic ren,
                        input logic fl, input logic clr, input logic rst);
      logic ovf_e, udf_e;
      int   lvl;
      preset = rst; Tx_wen = wen; Tx_data = data; rd_en = ren; flush = fl; err_clr = clr;
      @(posedge pclk);
      ovf_e = 1'b0;
      udf_e = 1'b0;
      if (rst) begin
         fifo_m.delete();
         m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
      end else if (fl) begin
         fifo_m.delete();
         if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
      end else begin
         if (ren) begin
            if (fifo_m.size() > 0) begin
               m_dout = fifo_m.pop_front();
               exp_q.push_back(m_dout);
            end else udf_e = 1'b1;
         end
         if (wen) begin
            if (fifo_m.size() < DEPTH) fifo_m.push_back(data);
            else ovf_e = 1'b1;
         end
         if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
         if (ovf_e) m_ovf = 1'b1;
         if (udf_e) m_udf = 1'b1;
      end
      #2;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL missing_vld: dout_vld=%0b expected 1 with 0x%0h at %0t", dout_vld, exp_q[0], $time);
         exp_q.delete();
      end
      lvl = fifo_m.size();
      check("level",  32'(Tx_level), 32'(lvl));
      check("full",   32'(Tx_full),   32'(lvl == DEPTH));
      check("empty",  32'(Tx_empty),  32'(lvl == 0));
      check("afull",  32'(Tx_afull),  32'(lvl >= 6));
      check("aempty", 32'(Tx_aempty), 32'(lvl <= 2));
      check("ovf",    32'(Tx_ovf),    32'(m_ovf));
      check("udf",    32'(Tx_udf),    32'(m_udf));
      check("dout",   dout, m_dout);
   endtask

   task automatic wr(input logic [DW-1:0] d); cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0); endtask
   task automatic rd();                       cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
   task automatic idle();                     cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

   initial begin
      m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      // Fill, overflow, drain in order
      for (int i = 0; i < 8; i++) wr(32'hA0 + 32'(i));
      wr(32'hDEAD);
      for (int i = 0; i < 8; i++) rd();
      idle();
      // Full with simultaneous write and read, then drain past the wrap
      for (int i = 0; i < 8; i++) wr(32'hB0 + 32'(i));
      cycle(1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) rd();
      // Underflow and sticky clear behaviour
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      rd();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      // Empty with simultaneous write and read
      cycle(1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b0);
      rd();
      // Flush with concurrent write and read
      for (int i = 0; i < 5; i++) wr(32'hC0 + 32'(i));
      cycle(1'b1, 32'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
      wr(32'h1234);
      rd();
      // Reset mid-stream with a read pending
      for (int i = 0; i < 4; i++) wr(32'hD0 + 32'(i));
      rd();
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
      idle();
      // Randomized phases alternating between fill-biased and drain-biased traffic
      for (int i = 0; i < 3000; i++) begin
         logic wen, ren, fl, clr, rst;
         bit   fillp;
         fillp = ((i / 48) % 2) == 0;
         wen = ($urandom_range(0, 99) < (fillp ? 80 : 25));
         ren = ($urandom_range(0, 99) < (fillp ? 25 : 80));
         fl  = ($urandom_range(0, 63) == 0);
         clr = !fl && ($urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 399) == 0);
         cycle(wen, $urandom(), ren, fl, clr, rst);
      end
      idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
